// File: rtl/ipsxb_fft_rst_gen.sv
// Reset sequencer for the FFT core: hold o_arstn low, release, settle, then wait for core ready.
// Optional wait-ready timeout enabled with `define IPSXB_FFT_RST_TIMEOUT_EN.
module ipsxb_fft_rst_gen #(
  parameter int HOLD_CYCLES    = 16,
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req,
  input  logic i_core_ready,
  output logic o_arstn,
  output logic o_busy,
  output logic o_done,
  output logic o_timeout
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ASSERT   = 2'd1;
  localparam logic [1:0] SETTLE   = 2'd2;
  localparam logic [1:0] WAIT_RDY = 2'd3;

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES >= 2**CNT_W) begin : g_hold_chk
    $error("HOLD_CYCLES out of range");
  end
  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES >= 2**CNT_W) begin : g_settle_chk
    $error("SETTLE_CYCLES out of range");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= 2**CNT_W) begin : g_timeout_chk
    $error("TIMEOUT_CYCLES out of range");
  end

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             done_nxt;
  logic             timeout_nxt;

`ifdef IPSXB_FFT_RST_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

  // A request wins over every other condition; each terminal count exits the state, so cnt never wraps.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    done_nxt    = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (i_req) begin
          state_nxt = ASSERT;
          cnt_nxt   = '0;
        end
      end
      ASSERT: begin
        if (i_req) begin
          cnt_nxt = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = SETTLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      SETTLE: begin
        if (i_req) begin
          state_nxt = ASSERT;
          cnt_nxt   = '0;
        end else if (cnt == SETTLE_LAST) begin
          state_nxt = WAIT_RDY;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      WAIT_RDY: begin
        if (i_req) begin
          state_nxt = ASSERT;
          cnt_nxt   = '0;
        end else if (i_core_ready) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
`ifdef IPSXB_FFT_RST_TIMEOUT_EN
          if (cnt == TIMEOUT_LAST) begin
            state_nxt   = IDLE;
            cnt_nxt     = '0;
            timeout_nxt = 1'b1;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
`else
          cnt_nxt = cnt;
`endif
        end
      end
      default: begin
        state_nxt = ASSERT;
        cnt_nxt   = '0;
      end
    endcase
  end

  logic timeout_q;

  // Outputs are registered and decoded from the next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ASSERT;
      cnt       <= '0;
      o_arstn   <= 1'b0;
      o_busy    <= 1'b1;
      o_done    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      o_arstn   <= (state_nxt != ASSERT);
      o_busy    <= (state_nxt != IDLE);
      o_done    <= done_nxt;
      timeout_q <= timeout_nxt;
    end
  end

`ifdef IPSXB_FFT_RST_TIMEOUT_EN
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
  logic unused_timeout;
  assign unused_timeout = timeout_q;
`endif

endmodule

// File: tb/tb_ipsxb_fft_rst_gen.sv
// Bench for ipsxb_fft_rst_gen: directed test-plan scenarios plus random traffic against a
// timestamp-based reference model (optionally with `define IPSXB_FFT_RST_TIMEOUT_EN).
module tb_ipsxb_fft_rst_gen;

  localparam int H = 4;
  localparam int S = 2;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0;
  logic core_ready = 1'b0;
  logic arstn, busy, done, timeout;

  ipsxb_fft_rst_gen #(
    .HOLD_CYCLES(H), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T), .CNT_W(16)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_core_ready(core_ready),
    .o_arstn(arstn), .o_busy(busy), .o_done(done), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_seen = 0;
  int to_seen = 0;

  // Model: the sequence is described by the cycle of the last trigger (reset or request)
  // and whether it has finished; the phase is the distance from that trigger.
  int trig = 0;
  bit finished = 1'b0;
  logic exp_arstn, exp_busy, exp_done, exp_to;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input int c, input bit r, input bit q, input bit rdy);
    int n;
    int d;
    exp_done = 1'b0;
    exp_to   = 1'b0;
    if (r || q) begin
      trig     = c;
      finished = 1'b0;
    end else if (!finished && (c - trig) >= H + S + 1) begin
      if (rdy) begin
        finished = 1'b1;
        exp_done = 1'b1;
      end
`ifdef IPSXB_FFT_RST_TIMEOUT_EN
      else if ((c - trig) - (H + S + 1) == T - 1) begin
        finished = 1'b1;
        exp_to   = 1'b1;
      end
`endif
    end
    n = c + 1;
    d = n - trig;
    if (finished) begin
      exp_arstn = 1'b1;
      exp_busy  = 1'b0;
    end else begin
      exp_arstn = (d > H);
      exp_busy  = 1'b1;
    end
  endtask

  task automatic tick(input bit r, input bit q, input bit rdy);
    rst = r;
    req = q;
    core_ready = rdy;
    model_step(cyc, r, q, rdy);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    chk("arstn", 32'(arstn), 32'(exp_arstn));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("done", 32'(done), 32'(exp_done));
    chk("timeout", 32'(timeout), 32'(exp_to));
    if (done === 1'b1) done_seen++;
    if (timeout === 1'b1) to_seen++;
  endtask

  initial begin
    // Power-up: reset for 3 cycles with ready high; done expected once, 8 cycles after release.
    for (int i = 0; i < 3; i++) tick(1, 0, 1);
    done_seen = 0;
    for (int i = 0; i < 12; i++) tick(0, 0, 1);
    chk("pwrup_done_cnt", 32'(done_seen), 32'd1);

    // Single request.
    tick(0, 1, 1);
    for (int i = 0; i < 10; i++) tick(0, 0, 1);

    // Hold extension.
    tick(0, 1, 1);
    tick(0, 0, 1);
    tick(0, 1, 1);
    for (int i = 0; i < 12; i++) tick(0, 0, 1);

    // Request during SETTLE.
    tick(0, 1, 1);
    for (int i = 0; i < 4; i++) tick(0, 0, 1);
    tick(0, 1, 1);
    for (int i = 0; i < 12; i++) tick(0, 0, 1);

    // Same-cycle request and ready in WAIT_RDY.
    tick(0, 1, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0);
    done_seen = 0;
    tick(0, 1, 1);
    chk("same_cycle_no_done", 32'(done_seen), 32'd0);
    for (int i = 0; i < 10; i++) tick(0, 0, 1);

    // Ready held low in WAIT_RDY.
    tick(0, 1, 0);
    to_seen = 0;
    for (int i = 0; i < 25; i++) tick(0, 0, 0);
`ifdef IPSXB_FFT_RST_TIMEOUT_EN
    chk("timeout_cnt", 32'(to_seen), 32'd1);
`else
    chk("timeout_cnt", 32'(to_seen), 32'd0);
`endif
    tick(0, 1, 1);
    for (int i = 0; i < 10; i++) tick(0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      tick(($urandom % 50) == 0, ($urandom % 14) == 0, ($urandom % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ipsxb_fft_rst_gen.md
# ipsxb_fft_rst_gen

Reset generator and sequencer that drives the active-low reset consumed by the FFT core's per-domain reset synchronizers. On power-up or on a request it holds `o_arstn` low for a fixed number of cycles. It then releases the reset and waits a settle window. Finally it waits for the core to report ready and signals completion with a one-cycle pulse. It sits in the control clock domain, upstream of every FFT-side reset synchronizer.

## Interface
- `HOLD_CYCLES`, 16: cycles `o_arstn` is held low; ≥1, <2^CNT_W.
- `SETTLE_CYCLES`, 8: cycles after release during which `i_core_ready` is ignored; ≥1, <2^CNT_W.
- `TIMEOUT_CYCLES`, 1024: wait-ready limit (macro-enabled only); ≥1, <2^CNT_W.
- `CNT_W`, 16: shared counter width.
- `i_clk`  in  1  single clock for all logic.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_req`  in  1  reset request, sampled each cycle (level or pulse).
- `i_core_ready`  in  1  downstream core reports out-of-reset and ready.
- `o_arstn`  out  1  registered active-low reset to downstream synchronizers.
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse when a sequence completes.
- `o_timeout`  out  1  one-cycle pulse when the wait for ready expires.

## Operation
- States: IDLE, ASSERT, SETTLE, WAIT_RDY. One shared counter, cleared on every state entry.
- All outputs are registered and decoded from the next state.
- Reset values while `i_rst`=1: state ASSERT, count 0, `o_arstn`=0, `o_busy`=1, `o_done`=0, `o_timeout`=0. Power-up therefore runs a full sequence with no request.
- IDLE: `o_arstn`=1. If `i_req`=1, go to ASSERT.
- ASSERT: `o_arstn`=0. After HOLD_CYCLES cycles in the state, go to SETTLE. If `i_req`=1, the count restarts at 0, which extends the hold.
- SETTLE: `o_arstn`=1. After SETTLE_CYCLES cycles, go to WAIT_RDY. `i_core_ready` is ignored in this state.
- WAIT_RDY: if `i_core_ready`=1, go to IDLE and pulse `o_done`.
- Request priority: `i_req`=1 in SETTLE or WAIT_RDY returns to ASSERT. This holds even when `i_core_ready`=1 in the same cycle; the request wins and no `o_done` is produced.
- Counter never wraps. It saturates at its terminal value because the state always exits there.

## Timing
- `i_req` sampled high in cycle n:
  - `o_arstn`=0 and `o_busy`=1 in cycles n+1 … n+HOLD_CYCLES.
  - `o_arstn`=1 from cycle n+HOLD_CYCLES+1.
  - SETTLE occupies n+HOLD_CYCLES+1 … n+HOLD_CYCLES+SETTLE_CYCLES.
  - WAIT_RDY starts at n+HOLD_CYCLES+SETTLE_CYCLES+1.
- `i_core_ready` sampled high in WAIT_RDY cycle m: `o_done`=1 and `o_busy`=0 in cycle m+1.
- Minimum request-to-done latency: HOLD_CYCLES+SETTLE_CYCLES+2 cycles.
- After `i_rst` is released in cycle r, `o_arstn` stays low through cycle r+HOLD_CYCLES. The counter does not count while `i_rst` is high.
- `o_done` and `o_timeout` are never high in the same cycle.

## Configuration
- Macro: `IPSXB_FFT_RST_TIMEOUT_EN`.
- Defined: WAIT_RDY counts cycles with `i_core_ready`=0. After TIMEOUT_CYCLES consecutive such cycles, the next cycle has `o_timeout`=1, state IDLE, `o_busy`=0 and `o_done`=0. `i_core_ready`=1 on the final counted cycle still completes with `o_done`.
- Not defined: WAIT_RDY waits indefinitely, `o_timeout` is tied to 0, and TIMEOUT_CYCLES is unused.

## Test plan
All scenarios use HOLD_CYCLES=4, SETTLE_CYCLES=2, TIMEOUT_CYCLES=8.
- Power-up: `i_rst` high for 3 cycles, then low, with `i_core_ready`=1. Required: `o_arstn` low through release+4, high from release+5, and `o_done` pulses exactly once at release+8.
- Request: single `i_req` pulse in cycle 10 with `i_core_ready`=1. Required: `o_arstn`=0 in cycles 11–14, SETTLE in 15–16, `o_done`=1 in 18, `o_busy` 0 from 18.
- Hold extension: `i_req` in cycle 10, again in cycle 12. Required: `o_arstn` low through cycle 16.
- Request during SETTLE: `i_req` in cycle 10 and again in cycle 15. Required: `o_arstn` low in 16–19 and no `o_done` before cycle 23.
- Same-cycle request and ready: `i_req` and `i_core_ready` both high in a WAIT_RDY cycle. Required: return to ASSERT, `o_done` stays 0.
- Timeout (macro defined): `i_core_ready` held 0. Required: `o_timeout` pulses once, 8 cycles after WAIT_RDY entry plus 1, then IDLE with `o_done`=0. With the macro undefined, the same stimulus leaves `o_busy`=1 forever and `o_timeout`=0.
